// File: rtl/toy_nlat_mem_model.sv
// Word-addressed SRAM model with N-cycle read latency.
// Request valid/ready in, credited read-response FIFO out.
module toy_nlat_mem_model #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wr_en,
  input  logic [DATA_WIDTH-1:0]   req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] req_wr_byte_en,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_data
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int NS = RD_LATENCY - 1;
  localparam int PW =
    (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int NW = 2 ** DEPTH_LOG2;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                 mem [NW];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hi_nz;
  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  push;
  logic                  pop;
  word_t                 rd_word;
  word_t                 push_data;

  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  word_t         fifo_q [RSP_DEPTH];
  word_t         fifo_d [RSP_DEPTH];

  assign idx    = req_addr[DEPTH_LOG2-1:0];
  assign hi_nz  = |req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign req_rdy =
    !rst && (out_q < CW'(RSP_DEPTH));
  assign acc    = req_vld && req_rdy;
  assign rd_acc = acc && !req_wr_en;
  assign wr_acc = acc && req_wr_en;
  assign rd_word = mem[idx];

  assign rsp_vld  = (cnt_q != '0);
  assign rsp_data = fifo_q[rp_q];
  assign pop      = rsp_vld && rsp_rdy;

  // Storage survives reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BW; i++) begin
        if (req_wr_byte_en[i]) begin
          mem[idx][8*i +: 8] <=
            req_wr_data[8*i +: 8];
        end
      end
    end
  end

  generate
    if (NS == 0) begin : g_nopipe
      assign push      = rd_acc;
      assign push_data = rd_word;
    end else begin : g_pipe
      logic [NS-1:0] pv_q, pv_d;
      word_t         pd_q [NS];
      word_t         pd_d [NS];

      always_comb begin
        pv_d[0] = rd_acc;
        pd_d[0] = rd_word;
        for (int i = 1; i < NS; i++) begin
          pv_d[i] = pv_q[i-1];
          pd_d[i] = pd_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv_q <= '0;
          for (int i = 0; i < NS; i++) begin
            pd_q[i] <= '0;
          end
        end else begin
          pv_q <= pv_d;
          for (int i = 0; i < NS; i++) begin
            pd_q[i] <= pd_d[i];
          end
        end
      end

      assign push      = pv_q[NS-1];
      assign push_data = pd_q[NS-1];
    end
  endgenerate

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wp_q] = push_data;
      wp_d = (wp_q == PW'(RSP_DEPTH - 1)) ?
        '0 : wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = (rp_q == PW'(RSP_DEPTH - 1)) ?
        '0 : rp_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    out_d = out_q + CW'(rd_acc) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fifo_q <= fifo_d;
    end
  end

  // Credits must keep the FIFO from ever overflowing.
  a_no_ovf: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop &&
      cnt_q == CW'(RSP_DEPTH)));

  c_alias: cover property (
    @(posedge clk) disable iff (rst)
    acc && hi_nz);

endmodule

// File: tb/tb_toy_nlat_mem_model.sv
// Directed bench: instance A is 1-cycle/2-deep,
// instance B is 3-cycle/4-deep.
module tb_toy_nlat_mem_model;

  logic        clk = 1'b0;
  int          n_run = 0;
  int          n_fail = 0;

  logic        a_rst, a_vld, a_rdy, a_wr;
  logic [31:0] a_addr, a_wdat, a_rdat;
  logic [3:0]  a_be;
  logic        a_rvld, a_rrdy;

  logic        b_rst, b_vld, b_rdy, b_wr;
  logic [31:0] b_addr, b_wdat, b_rdat;
  logic [3:0]  b_be;
  logic        b_rvld, b_rrdy;

  always #5 clk = ~clk;

  toy_nlat_mem_model #(
    .RD_LATENCY(1),
    .RSP_DEPTH (2)
  ) u_a (
    .clk           (clk),
    .rst           (a_rst),
    .req_vld       (a_vld),
    .req_rdy       (a_rdy),
    .req_addr      (a_addr),
    .req_wr_en     (a_wr),
    .req_wr_data   (a_wdat),
    .req_wr_byte_en(a_be),
    .rsp_vld       (a_rvld),
    .rsp_rdy       (a_rrdy),
    .rsp_data      (a_rdat)
  );

  toy_nlat_mem_model #(
    .RD_LATENCY(3),
    .RSP_DEPTH (4)
  ) u_b (
    .clk           (clk),
    .rst           (b_rst),
    .req_vld       (b_vld),
    .req_rdy       (b_rdy),
    .req_addr      (b_addr),
    .req_wr_en     (b_wr),
    .req_wr_data   (b_wdat),
    .req_wr_byte_en(b_be),
    .rsp_vld       (b_rvld),
    .rsp_rdy       (b_rrdy),
    .rsp_data      (b_rdat)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge
  // following the accept edge.
  task automatic a_req(input logic        wr,
                       input logic [31:0] ad,
                       input logic [31:0] dt,
                       input logic [3:0]  be);
    int n = 0;
    a_vld = 1'b1; a_wr = wr; a_addr = ad;
    a_wdat = dt; a_be = be;
    while (!a_rdy && n < 50) begin
      @(negedge clk); n++;
    end
    if (!a_rdy) chk("a_req_timeout", 0, 1);
    @(negedge clk);
    a_vld = 1'b0;
  endtask

  task automatic b_req(input logic        wr,
                       input logic [31:0] ad,
                       input logic [31:0] dt,
                       input logic [3:0]  be);
    int n = 0;
    b_vld = 1'b1; b_wr = wr; b_addr = ad;
    b_wdat = dt; b_be = be;
    while (!b_rdy && n < 50) begin
      @(negedge clk); n++;
    end
    if (!b_rdy) chk("b_req_timeout", 0, 1);
    @(negedge clk);
    b_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_rst = 1'b1; a_vld = 1'b0; a_wr = 1'b0;
    a_addr = '0; a_wdat = '0; a_be = '0;
    a_rrdy = 1'b1;
    b_rst = 1'b1; b_vld = 1'b0; b_wr = 1'b0;
    b_addr = '0; b_wdat = '0; b_be = '0;
    b_rrdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_rdy", a_rdy, 0);
    chk("rst_a_vld", a_rvld, 0);
    chk("rst_a_data", a_rdat, 0);
    chk("rst_b_rdy", b_rdy, 0);
    chk("rst_b_vld", b_rvld, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("rel_a_rdy", a_rdy, 1);
    chk("rel_b_rdy", b_rdy, 1);

    // Full write then read, latency 1
    a_req(1, 32'h4, 32'hDEADBEEF, 4'hF);
    a_req(0, 32'h4, 0, 4'h0);
    chk("t1_vld", a_rvld, 1);
    chk("t1_data", a_rdat, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_popped", a_rvld, 0);

    // Byte-enable merge
    a_req(1, 32'h8, 32'h11223344, 4'hF);
    a_req(1, 32'h8, 32'hAABBCCDD, 4'b0101);
    a_req(0, 32'h8, 0, 4'h0);
    chk("t2_data", a_rdat, 32'h11BB33DD);
    @(negedge clk);

    // Aliasing above DEPTH_LOG2
    a_req(1, 32'h400, 32'h5A5A5A5A, 4'hF);
    a_req(0, 32'h000, 0, 4'h0);
    chk("t6_data", a_rdat, 32'h5A5A5A5A);
    @(negedge clk);

    // Backpressure with 2 credits
    a_rrdy = 1'b0;
    a_req(0, 32'h4, 0, 4'h0);
    a_req(0, 32'h8, 0, 4'h0);
    chk("t4_rdy_full", a_rdy, 0);
    chk("t4_vld", a_rvld, 1);
    chk("t4_head", a_rdat, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    chk("t4_hold", a_rdat, 32'hDEADBEEF);
    chk("t4_rdy_hold", a_rdy, 0);
    a_vld = 1'b1; a_wr = 1'b0; a_addr = 32'h0;
    a_rrdy = 1'b1;
    @(negedge clk);
    chk("t4_rd2", a_rdat, 32'h11BB33DD);
    chk("t4_rdy_back", a_rdy, 1);
    @(negedge clk);
    a_vld = 1'b0;
    chk("t4_vld3", a_rvld, 1);
    chk("t4_rd3", a_rdat, 32'h5A5A5A5A);
    @(negedge clk);
    chk("t4_empty", a_rvld, 0);

    // Back-to-back reads, latency 3
    for (int i = 0; i < 4; i++)
      b_req(1, i, 32'hC0DE0000 + i, 4'hF);
    b_vld = 1'b1; b_wr = 1'b0; b_addr = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 3) b_addr = k + 1;
      else b_vld = 1'b0;
      chk($sformatf("t3_vld%0d", k), b_rvld,
          (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5)
        chk($sformatf("t3_dat%0d", k), b_rdat,
            32'hC0DE0000 + k - 2);
    end

    // Reset with two reads in flight
    b_vld = 1'b1; b_wr = 1'b0; b_addr = 1;
    @(negedge clk);
    b_addr = 2;
    @(negedge clk);
    b_vld = 1'b0;
    b_rst = 1'b1;
    #1;
    chk("t5_rst_rdy", b_rdy, 0);
    chk("t5_rst_vld", b_rvld, 0);
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    chk("t5_rdy", b_rdy, 1);
    n = 0;
    repeat (6) begin
      if (b_rvld) n++;
      @(negedge clk);
    end
    chk("t5_no_rsp", n, 0);
    b_req(0, 32'h2, 0, 4'h0);
    n = 0;
    while (!b_rvld && n < 10) begin
      @(negedge clk); n++;
    end
    chk("t5_lat", n, 2);
    chk("t5_data", b_rdat, 32'hC0DE0002);
    @(negedge clk);
    chk("t5_empty", b_rvld, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
